data_cache: RTL

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/dcache_pkg.sv | 67 ++++++
 rtl/dcache_lane.sv | 34 +++
 rtl/data_cache.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and big-endian byte-lane helpers for data_cache
package dcache_pkg;

    // Access size decoded from func3
    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    // Cache controller states
    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE
    } state_e;

    // func3 -> access size; unknown encodings behave as a word access
    function automatic size_e f3_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: f3_size = SZ_BYTE;
            3'b001, 3'b101: f3_size = SZ_HALF;
            default:        f3_size = SZ_WORD;
        endcase
    endfunction

    // Only lb and lh sign-extend
    function automatic logic f3_signed(input logic [2:0] f3);
        f3_signed = (f3 == 3'b000) || (f3 == 3'b001);
    endfunction

    // Byte enables, bit3 = byte at offset 0 (bits [31:24])
    function automatic logic [3:0] lane_be(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: begin
                case (off)
                    2'd0:    lane_be = 4'b1000;
                    2'd1:    lane_be = 4'b0100;
                    2'd2:    lane_be = 4'b0010;
                    default: lane_be = 4'b0001;
                endcase
            end
            SZ_HALF: lane_be = off[1] ? 4'b0011 : 4'b1100;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    // Store data replicated across lanes so every enabled lane sees the right bytes
    function automatic logic [31:0] lane_wdata(input size_e sz, input logic [31:0] din);
        case (sz)
            SZ_BYTE: lane_wdata = {4{din[7:0]}};
            SZ_HALF: lane_wdata = {2{din[15:0]}};
            default: lane_wdata = din;
        endcase
    endfunction

    // Replace only the enabled bytes of a stored word
    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
        lane_merge = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) lane_merge[i*8 +: 8] = new_w[i*8 +: 8];
        end
    endfunction

endpackage

// File: rtl/dcache_lane.sv
// rtl/dcache_lane.sv - combinational load extraction with sign/zero extension
module dcache_lane
    import dcache_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  func3,
    output logic [31:0] dout
);

    size_e       sz;
    logic        sgn;
    logic [7:0]  b;
    logic [15:0] h;

    // Pick the addressed byte/halfword (big-endian) and extend it
    always_comb begin
        sz  = f3_size(func3);
        sgn = f3_signed(func3);
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (sz)
            SZ_BYTE: dout = {{24{sgn & b[7]}}, b};
            SZ_HALF: dout = {{16{sgn & h[15]}}, h};
            default: dout = word;
        endcase
    end

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through data cache; DCACHE_STATS_EN adds hit/miss counters
module data_cache
    import dcache_pkg::*;
#(
    parameter int WA        = 32,
    parameter int WD        = 32,
    parameter int SETS_LOG2 = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [WA-1:0] Ad,
    input  logic          RamRead,
    input  logic          RamWrite,
    input  logic [2:0]    func3,
    input  logic [WD-1:0] DIn,
    output logic [WD-1:0] DOut,
    output logic          Stall,
    output logic          MemReq,
    output logic          MemWe,
    output logic [WA-1:0] MemAd,
    output logic [WD-1:0] MemWData,
    output logic [3:0]    MemByteEn,
    input  logic [WD-1:0] MemRData,
    input  logic          MemAck,
    output logic [31:0]   HitCount,
    output logic [31:0]   MissCount
);

    localparam int SETS = 1 << SETS_LOG2;
    localparam int TW   = WA - SETS_LOG2 - 2;

    state_e state_q, state_d;

    logic [WA-1:0] ad_q;
    logic [WD-1:0] din_q;
    logic [2:0]    f3_q;

    logic [TW-1:0] tag_mem  [SETS];
    logic [WD-1:0] data_mem [SETS];
    logic [SETS-1:0] valid_q;

    logic [SETS_LOG2-1:0] idx, q_idx;
    logic [TW-1:0]        tag, q_tag;
    logic                 hit, q_hit;

    logic [WD-1:0] lane_word, lane_dout;
    logic [1:0]    lane_off;
    logic [2:0]    lane_f3;

    logic fill_we, store_we, hit_evt, miss_evt;

    assign idx   = Ad[SETS_LOG2+1:2];
    assign tag   = Ad[WA-1:SETS_LOG2+2];
    assign q_idx = ad_q[SETS_LOG2+1:2];
    assign q_tag = ad_q[WA-1:SETS_LOG2+2];
    assign hit   = valid_q[idx] && (tag_mem[idx] == tag);
    assign q_hit = valid_q[q_idx] && (tag_mem[q_idx] == q_tag);

    // One extractor serves both hit data and fill data; FILL uses the latched request
    assign lane_word = (state_q == FILL) ? MemRData : data_mem[idx];
    assign lane_off  = (state_q == FILL) ? ad_q[1:0] : Ad[1:0];
    assign lane_f3   = (state_q == FILL) ? f3_q : func3;

    dcache_lane u_lane (
        .word  (lane_word),
        .off   (lane_off),
        .func3 (lane_f3),
        .dout  (lane_dout)
    );

    // Next-state and output decode; memory side is driven only from latched request
    always_comb begin
        state_d   = state_q;
        Stall     = 1'b0;
        DOut      = '0;
        MemReq    = 1'b0;
        MemWe     = 1'b0;
        MemAd     = '0;
        MemWData  = '0;
        MemByteEn = 4'b0000;
        fill_we   = 1'b0;
        store_we  = 1'b0;
        hit_evt   = 1'b0;
        miss_evt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (RamWrite) begin
                    Stall   = 1'b1;
                    state_d = WRITE;
                end else if (RamRead) begin
                    if (hit) begin
                        DOut    = lane_dout;
                        hit_evt = 1'b1;
                    end else begin
                        Stall    = 1'b1;
                        state_d  = FILL;
                        miss_evt = 1'b1;
                    end
                end
            end
            FILL: begin
                MemReq = 1'b1;
                MemAd  = {ad_q[WA-1:2], 2'b00};
                if (MemAck) begin
                    DOut    = lane_dout;
                    fill_we = 1'b1;
                    state_d = IDLE;
                end else begin
                    Stall = 1'b1;
                end
            end
            WRITE: begin
                MemReq    = 1'b1;
                MemWe     = 1'b1;
                MemAd     = {ad_q[WA-1:2], 2'b00};
                MemByteEn = lane_be(f3_size(f3_q), ad_q[1:0]);
                MemWData  = lane_wdata(f3_size(f3_q), din_q);
                if (MemAck) begin
                    store_we = q_hit;
                    state_d  = IDLE;
                end else begin
                    Stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Request latch: sampled while idle so the memory side stays stable during a transfer
    always_ff @(posedge clk) begin
        if (state_q == IDLE) begin
            ad_q  <= Ad;
            din_q <= DIn;
            f3_q  <= func3;
        end
    end

    // Valid bits; reset wins over a fill acked in the same cycle
    always_ff @(posedge clk) begin
        if (rst)          valid_q        <= '0;
        else if (fill_we) valid_q[q_idx] <= 1'b1;
    end

    // Line data and tags, never reset; stores update only lines already present
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (fill_we) begin
                data_mem[q_idx] <= MemRData;
                tag_mem[q_idx]  <= q_tag;
            end else if (store_we) begin
                data_mem[q_idx] <= lane_merge(data_mem[q_idx], MemWData, MemByteEn);
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Saturating hit/miss statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_evt && hit_cnt_q != 32'hFFFF_FFFF)   hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_evt && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign HitCount  = hit_cnt_q;
    assign MissCount = miss_cnt_q;
`else
    assign HitCount  = 32'd0;
    assign MissCount = 32'd0;
`endif

endmodule
